// File: rtl/bus_pkg.sv
// bus_pkg: types and constants shared by the serial slave port and the arbiter.
// Optional feature macro: SLAVE_PARITY_EN (adds the PAR state to state_t).
package bus_pkg;

  localparam int BUS_ADDR_W = 12;
  localparam int BUS_DATA_W = 8;

`ifdef SLAVE_PARITY_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    PAR   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    WRITE = 2'd3
  } state_t;
`endif

  // Bit counter width: enough to hold the longest field length without wrapping.
  function automatic int cnt_width(input int a_w, input int d_w);
    return $clog2(((a_w > d_w) ? a_w : d_w) + 1);
  endfunction

endpackage

// File: rtl/serial_slave_port_if.sv
// serial_slave_port_if: frame handshake between the arbiter (master) and the port (slave).
// Handshake: the master raises s_valid only while s_ready is high and then keeps it
// high for the whole frame, presenting one address bit per cycle on s_address and
// then one data bit per cycle on s_data, MSB first. s_ready is high only when the
// slave is idle. Dropping s_valid before the frame ends aborts the frame.
interface serial_slave_port_if;
  logic s_valid;
  logic s_address;
  logic s_data;
  logic s_ready;

  modport master (output s_valid, output s_address, output s_data, input s_ready);
  modport slave  (input s_valid, input s_address, input s_data, output s_ready);
endinterface

// File: rtl/sipo_shift.sv
// sipo_shift: serial-in parallel-out shift register, MSB arrives first.
// Clear has priority over shift-enable.
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: clear, shift one bit in at the LSB, or hold.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = {q_q[WIDTH-2:0], d_i};
    end
  end

  // Shift register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_slave_port.sv
// serial_slave_port: receives serial address/data frames and commits each complete
// frame as one word into a local memory with an asynchronous debug read port.
// Optional feature macro: SLAVE_PARITY_EN (even parity bit after the data field,
// PAR state and sticky parity_err output).
module serial_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_W    = BUS_ADDR_W,
  parameter int DATA_W    = BUS_DATA_W,
  parameter int MEM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              reset,
  serial_slave_port_if.slave bus,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_abort,
`ifdef SLAVE_PARITY_EN
  output logic              parity_err,
`endif
  output state_t            dbg_state_o
);

  localparam int CNT_W = cnt_width(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              addr_en;
  logic              data_en;
  logic              shift_clr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
`ifdef SLAVE_PARITY_EN
  logic              perr_q, perr_d;
  logic              par_exp;

  // Even parity: the received bit must make the total count of ones even.
  assign par_exp = ^{addr_q, data_q};
`endif

  sipo_shift #(.WIDTH(ADDR_W)) u_addr_shift (
    .clk   (clk),
    .reset (reset),
    .clr_i (shift_clr),
    .en_i  (addr_en),
    .d_i   (bus.s_address),
    .q_o   (addr_q)
  );

  sipo_shift #(.WIDTH(DATA_W)) u_data_shift (
    .clk   (clk),
    .reset (reset),
    .clr_i (shift_clr),
    .en_i  (data_en),
    .d_i   (bus.s_data),
    .q_o   (data_q)
  );

  // Frame sequencing: next state, bit counter, shift enables and abort/parity flags.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
    addr_en   = 1'b0;
    data_en   = 1'b0;
    shift_clr = 1'b0;
`ifdef SLAVE_PARITY_EN
    perr_d    = perr_q;
`endif
    case (state_q)
      IDLE: begin
        // Acceptance edge only; the first address bit is sampled on the next edge.
        if (bus.s_valid) begin
          state_d   = ADDR;
          cnt_d     = '0;
          shift_clr = 1'b1;
        end
      end
      ADDR: begin
        if (!bus.s_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else begin
          addr_en = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (!bus.s_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else begin
          data_en = 1'b1;
          if (cnt_q == DATA_LAST) begin
`ifdef SLAVE_PARITY_EN
            state_d = PAR;
`else
            state_d = WRITE;
`endif
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SLAVE_PARITY_EN
      PAR: begin
        cnt_d = '0;
        if (!bus.s_valid) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (bus.s_data == par_exp) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
          perr_d  = 1'b1;
        end
      end
`endif
      WRITE: begin
        // s_valid is deliberately ignored here; IDLE decides on the next frame.
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
`ifdef SLAVE_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
`ifdef SLAVE_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Word memory: not reset, written only at the edge closing WRITE.
  always_ff @(posedge clk) begin
    if (state_q == WRITE) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign bus.s_ready = (state_q == IDLE);
  assign wr_strobe   = (state_q == WRITE);
  assign wr_addr     = addr_q;
  assign wr_data     = data_q;
  assign rd_data     = mem_q[rd_addr];
  assign frame_abort = abort_q;
  assign dbg_state_o = state_q;
`ifdef SLAVE_PARITY_EN
  assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_serial_slave_port.sv
// tb_serial_slave_port: table-driven and randomized frames against a frame-level
// reference model (expected write queue plus an associative memory image).
// Optional feature macro: SLAVE_PARITY_EN (exercises the parity bit and parity_err).
module tb_serial_slave_port;
  import bus_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
`ifdef SLAVE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FULL      = ADDR_W + DATA_W + PB;  // serial bits in a frame
  localparam int FRAME_LOW = FULL + 1;              // s_ready low cycles of a committed frame

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_slave_port_if bus_if ();
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_abort;
`ifdef SLAVE_PARITY_EN
  logic              parity_err;
`endif
  state_t            dbg_state;

  serial_slave_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(4096)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_abort (frame_abort),
`ifdef SLAVE_PARITY_EN
    .parity_err  (parity_err),
`endif
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]        model_mem [int];
  int n_vec  = 0;
  int n_miss = 0;
  int low_cnt, strobe_cnt, abort_cnt, high_run, last_gap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic even_par(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return 1'(($countones(a) + $countones(d)) % 2);
  endfunction

  // Samples outputs 1 time unit after each rising edge.
  task automatic observe();
    logic [ADDR_W+DATA_W-1:0] w;
    if (bus_if.s_ready) begin
      high_run++;
    end else begin
      if (high_run != 0) last_gap = high_run;
      high_run = 0;
      low_cnt++;
    end
    if (frame_abort) abort_cnt++;
    if (wr_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, no write expected", wr_addr, wr_data);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(w[ADDR_W+DATA_W-1:DATA_W]));
        check("wr_data", 32'(wr_data), 32'(w[DATA_W-1:0]));
        if (model_mem.exists(int'(w[ADDR_W+DATA_W-1:DATA_W]))) begin
          rd_addr = w[ADDR_W+DATA_W-1:DATA_W];
          #1;
          check("rd_during_write_old", 32'(rd_data), 32'(model_mem[int'(w[ADDR_W+DATA_W-1:DATA_W])]));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    observe();
  endtask

  // ---------------- driver ----------------
  task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int bits_valid, input bit bad_par, input bit hold,
                            input bit exp_wr);
    bit keep;
    keep       = hold && exp_wr;
    low_cnt    = 0;
    strobe_cnt = 0;
    abort_cnt  = 0;
    if (exp_wr) exp_q.push_back({a, d});
    bus_if.s_valid = 1'b1;
    step();
    for (int i = 0; i < FULL && i < bits_valid; i++) begin
      if (i < ADDR_W) begin
        bus_if.s_address = a[ADDR_W-1-i];
        bus_if.s_data    = 1'($urandom);
      end else if (i < ADDR_W + DATA_W) begin
        bus_if.s_address = 1'($urandom);
        bus_if.s_data    = d[ADDR_W+DATA_W-1-i];
      end else begin
        bus_if.s_address = 1'($urandom);
        bus_if.s_data    = even_par(a, d) ^ bad_par;
      end
      step();
    end
    if (bits_valid < FULL) begin
      bus_if.s_valid = 1'b0;
      step();
      step();
    end else begin
      if (!keep) bus_if.s_valid = 1'b0;
      step();
      if (!keep) step();
    end
    if (exp_wr) model_mem[int'(a)] = d;
  endtask

  task automatic run_frame(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input int bits_valid, input bit bad_par, input bit hold,
                           input int exp_low, input bit exp_wr, input bit exp_ab, input int exp_gap);
    send_frame(a, d, bits_valid, bad_par, hold, exp_wr);
    check({tag, "_ready_low"}, 32'(low_cnt), 32'(exp_low));
    check({tag, "_strobes"}, 32'(strobe_cnt), 32'(exp_wr));
    check({tag, "_aborts"}, 32'(abort_cnt), 32'(exp_ab));
    if (exp_gap != 0) check({tag, "_gap"}, 32'(last_gap), 32'(exp_gap));
    rd_addr = a;
    #1;
    if (model_mem.exists(int'(a))) check({tag, "_readback"}, 32'(rd_data), 32'(model_mem[int'(a)]));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                bits_valid;
    bit                bad_par;
    bit                hold;
    int                exp_low;
    bit                exp_wr;
    bit                exp_ab;
    int                exp_gap;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_keep;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    int  rbits;
    bit  rbad, rhold, rwr, rab;
    int  rlow;

    vecs[0] = '{12'hABC, 8'h5A, FULL,        1'b0, 1'b0, FRAME_LOW, 1'b1, 1'b0, 0};
    vecs[1] = '{12'h001, 8'h11, FULL,        1'b0, 1'b1, FRAME_LOW, 1'b1, 1'b0, 0};
    vecs[2] = '{12'h002, 8'h22, FULL,        1'b0, 1'b0, FRAME_LOW, 1'b1, 1'b0, 1};
    vecs[3] = '{12'hABC, 8'h77, ADDR_W + 5,  1'b0, 1'b0, 18,        1'b0, 1'b1, 0};
    vecs[4] = '{12'hABC, 8'hA5, FULL,        1'b0, 1'b0, FRAME_LOW, 1'b1, 1'b0, 0};
    vecs[5] = '{12'h3FF, 8'h00, 0,           1'b0, 1'b0, 1,         1'b0, 1'b1, 0};
    vecs[6] = '{12'hFFF, 8'hFF, FULL,        1'b0, 1'b1, FRAME_LOW, 1'b1, 1'b0, 0};
    vecs[7] = '{12'h000, 8'h80, 11,          1'b0, 1'b0, 12,        1'b0, 1'b1, 1};
    vecs[8] = '{12'h555, 8'h01, ADDR_W + DATA_W - 1, 1'b0, 1'b0, 20, 1'b0, 1'b1, 0};

    reset            = 1'b0;
    bus_if.s_valid   = 1'b0;
    bus_if.s_address = 1'b0;
    bus_if.s_data    = 1'b0;
    rd_addr          = '0;
    high_run         = 0;
    last_gap         = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_ready", 32'(bus_if.s_ready), 32'd1);
    check("reset_wr_strobe", 32'(wr_strobe), 32'd0);
    check("reset_frame_abort", 32'(frame_abort), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
`ifdef SLAVE_PARITY_EN
    check("reset_parity_err", 32'(parity_err), 32'd0);
`endif
    reset = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].bits_valid,
                vecs[i].bad_par, vecs[i].hold, vecs[i].exp_low, vecs[i].exp_wr,
                vecs[i].exp_ab, vecs[i].exp_gap);
    end

`ifdef SLAVE_PARITY_EN
    // Wrong parity: no write, sticky error; a correct frame afterwards still commits.
    run_frame("par_bad", 12'h010, 8'hFF, FULL, 1'b1, 1'b0, FULL, 1'b0, 1'b0, 0);
    check("par_err_set", 32'(parity_err), 32'd1);
    run_frame("par_good", 12'h010, 8'hFF, FULL, 1'b0, 1'b0, FRAME_LOW, 1'b1, 1'b0, 0);
    check("par_err_sticky", 32'(parity_err), 32'd1);
    run_frame("par_abort", 12'h020, 8'h0F, ADDR_W + DATA_W, 1'b0, 1'b0, ADDR_W + DATA_W + 1, 1'b0, 1'b1, 0);
`endif

    // Reset in the middle of the address field.
    bus_if.s_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      bus_if.s_address = 1'($urandom);
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    check("midrst_s_ready", 32'(bus_if.s_ready), 32'd1);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("midrst_frame_abort", 32'(frame_abort), 32'd0);
`ifdef SLAVE_PARITY_EN
    check("midrst_parity_err", 32'(parity_err), 32'd0);
`endif
    bus_if.s_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    rd_addr = 12'hABC;
    #1;
    check("midrst_mem_kept", 32'(rd_data), 32'(model_mem[int'(12'hABC)]));
    run_frame("midrst_next", 12'h123, 8'h3C, FULL, 1'b0, 1'b0, FRAME_LOW, 1'b1, 1'b0, 0);

    // Randomized frames judged by frame-level rules.
    prev_keep = 1'b0;
    for (int n = 0; n < 40; n++) begin
      ra    = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      rdat  = DATA_W'($urandom);
      rbits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, FULL - 1) : FULL;
      rhold = 1'($urandom);
      rbad  = (PB == 1) && ($urandom_range(0, 4) == 0);
      if (rbits < FULL) begin
        rlow = rbits + 1; rwr = 1'b0; rab = 1'b1;
      end else if (rbad) begin
        rlow = FULL; rwr = 1'b0; rab = 1'b0;
      end else begin
        rlow = FULL + 1; rwr = 1'b1; rab = 1'b0;
      end
      run_frame($sformatf("rnd%0d", n), ra, rdat, rbits, rbad, rhold, rlow, rwr, rab,
                prev_keep ? 1 : 0);
      prev_keep = rhold && rwr;
    end
    bus_if.s_valid = 1'b0;
    step();
    step();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
